// File: rtl/ys_poly_small_ctrl.sv
// Read/write sequencer for a mode-3 pass: streams RAM1 beats (two words each)
// through the datapath and writes results to RAM2 RD_LAT cycles later.
module ys_poly_small_ctrl #(
    parameter int unsigned NTRU_N = 509,
    parameter int unsigned AW     = 7,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ram1_ena,
    output logic          ram1_enb,
    output logic [AW-1:0] ram1_addra,
    output logic [AW-1:0] ram1_addrb,
    output logic          ram2_wea,
    output logic          ram2_web,
    output logic [AW-1:0] ram2_addra,
    output logic [AW-1:0] ram2_addrb,
    output logic          f_ctr
);

    localparam int unsigned BEATS = (NTRU_N + 7) / 8;
    localparam int unsigned KW    = $clog2(BEATS + 1);

    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
        $error("ys_poly_small_ctrl: RD_LAT must be 1 or 2");
    end
    if (BEATS * 2 > (1 << AW)) begin : g_bad_aw
        $error("ys_poly_small_ctrl: AW too small for 2*BEATS words");
    end

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [KW-1:0] k_inc;
    logic          src_v;
    logic [KW-1:0] src_k;

    assign k_inc = k + KW'(1);

    // {valid, beat} of the read whose data arrives in the next cycle
    if (RD_LAT == 1) begin : g_lat1
        assign src_v = ram1_ena;
        assign src_k = k;
    end else begin : g_latn
        logic          pv [RD_LAT-1];
        logic [KW-1:0] pk [RD_LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
                    pv[i] <= 1'b0;
                    pk[i] <= '0;
                end
            end else begin
                pv[0] <= ram1_ena;
                pk[0] <= k;
                for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
                    pv[i] <= pv[i-1];
                    pk[i] <= pk[i-1];
                end
            end
        end

        assign src_v = pv[RD_LAT-2];
        assign src_k = pk[RD_LAT-2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram1_ena   <= 1'b0;
            ram1_enb   <= 1'b0;
            ram1_addra <= '0;
            ram1_addrb <= '0;
            ram2_wea   <= 1'b0;
            ram2_web   <= 1'b0;
            ram2_addra <= '0;
            ram2_addrb <= '0;
            f_ctr      <= 1'b1;
        end else begin
            done       <= 1'b0;
            ram2_wea   <= src_v;
            ram2_web   <= src_v;
            ram2_addra <= src_v ? AW'({src_k, 1'b0}) : '0;
            ram2_addrb <= src_v ? AW'({src_k, 1'b1}) : '0;
            f_ctr      <= !(src_v && src_k == '0);

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= READ;
                        k          <= '0;
                        busy       <= 1'b1;
                        ram1_ena   <= 1'b1;
                        ram1_enb   <= 1'b1;
                        ram1_addra <= '0;
                        ram1_addrb <= AW'(1);
                    end
                end
                READ: begin
                    if (k == KW'(BEATS - 1)) begin
                        state      <= DRAIN;
                        ram1_ena   <= 1'b0;
                        ram1_enb   <= 1'b0;
                        ram1_addra <= '0;
                        ram1_addrb <= '0;
                    end else begin
                        k          <= k_inc;
                        ram1_addra <= AW'({k_inc, 1'b0});
                        ram1_addrb <= AW'({k_inc, 1'b1});
                    end
                end
                DRAIN: begin
                    // the write now on the outputs is the last one
                    if (!src_v) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
